// File: rtl/rv32_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory port, one transaction in flight.
// Data wins by default; a fetch denied for STARVE_LIMIT cycles is forced through.
module rv32_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,

  output logic        busy_o,
  output logic        protocol_err_o
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  state_e          state_q;
  owner_e          owner_q;
  owner_e          sel;
  logic            req;
  logic [SW-1:0]   starve_q;
  logic            err_q;

  // Owner selection: live arbitration in IDLE, locked owner while waiting for grant
  always_comb begin
    sel = owner_q;
    req = 1'b0;
    unique case (state_q)
      IDLE: begin
        req = instr_req_i | data_req_i;
        sel = (data_req_i && !(instr_req_i && (starve_q >= STARVE_MAX))) ? OWN_DATA : OWN_INSTR;
      end
      HOLD: begin
        req = 1'b1;
        sel = owner_q;
      end
      default: ;
    endcase
  end

  // Memory-side request mux; fields forced to zero when idle
  always_comb begin
    mem_req_o   = req;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (req) begin
      if (sel == OWN_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  assign instr_gnt_o    = req & mem_gnt_i & (sel == OWN_INSTR);
  assign data_gnt_o     = req & mem_gnt_i & (sel == OWN_DATA);
  assign instr_rvalid_o = mem_rvalid_i & (state_q == RESP) & (owner_q == OWN_INSTR);
  assign data_rvalid_o  = mem_rvalid_i & (state_q == RESP) & (owner_q == OWN_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign busy_o         = (state_q != IDLE);
  assign protocol_err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= OWN_INSTR;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (req) begin
          owner_q <= sel;
          state_q <= mem_gnt_i ? RESP : HOLD;
        end
        HOLD: if (mem_gnt_i) state_q <= RESP;
        RESP: if (mem_rvalid_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // A response with nothing outstanding is a memory-side protocol violation
      if (mem_rvalid_i && (state_q != RESP)) err_q <= 1'b1;

      if (instr_req_i && !instr_gnt_o) begin
        if (starve_q < STARVE_MAX) starve_q <= starve_q + SW'(1);
      end else begin
        starve_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Self-checking bench for rv32_mem_arbiter: IDLE vector table, directed corner cases,
// and randomized traffic against a transaction-level reference model.
module tb_rv32_mem_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ir, dr, dwe, mem_gnt, mem_rvalid;
  logic [31:0] ia, da, dwd, mem_rdata;
  logic [3:0]  dbe;
  logic        igt, irv, dgt, drv, mreq, mwe, busy, perr;
  logic [31:0] irdata, drdata, maddr, mwdata;
  logic [3:0]  mbe;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(ir), .instr_addr_i(ia), .instr_gnt_o(igt),
    .instr_rvalid_o(irv), .instr_rdata_o(irdata),
    .data_req_i(dr), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(da),
    .data_wdata_i(dwd), .data_gnt_o(dgt), .data_rvalid_o(drv), .data_rdata_o(drdata),
    .mem_req_o(mreq), .mem_we_o(mwe), .mem_be_o(mbe), .mem_addr_o(maddr),
    .mem_wdata_o(mwdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .protocol_err_o(perr)
  );

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        igt;
    logic        dgt;
    logic        irv;
    logic        drv;
    logic [31:0] irdata;
    logic [31:0] drdata;
    logic        busy;
    logic        err;
  } outs_t;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        gnt;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        e_igt;
    logic        e_dgt;
  } vec_t;

  // Reference model: phase 0 = nothing outstanding, 1 = asked but not granted, 2 = awaiting data
  int m_phase;
  bit m_own_data;
  bit m_sel_data;
  int m_starve;
  bit m_err;

  function automatic void model_reset();
    m_phase    = 0;
    m_own_data = 1'b0;
    m_starve   = 0;
    m_err      = 1'b0;
  endfunction

  function automatic outs_t model_outs();
    outs_t o;
    bit    req;
    o = '0;
    req = 1'b0;
    m_sel_data = m_own_data;
    if (m_phase == 0) begin
      req = ir | dr;
      m_sel_data = dr && !(ir && (m_starve >= int'(LIMIT)));
    end else if (m_phase == 1) begin
      req = 1'b1;
    end
    o.req = req;
    if (req && m_sel_data) begin
      o.we = dwe; o.be = dbe; o.addr = da; o.wdata = dwd;
    end else if (req) begin
      o.be = 4'hF; o.addr = ia;
    end
    o.igt    = req && mem_gnt && !m_sel_data;
    o.dgt    = req && mem_gnt && m_sel_data;
    o.irv    = mem_rvalid && (m_phase == 2) && !m_own_data;
    o.drv    = mem_rvalid && (m_phase == 2) && m_own_data;
    o.irdata = mem_rdata;
    o.drdata = mem_rdata;
    o.busy   = (m_phase != 0);
    o.err    = m_err;
    return o;
  endfunction

  function automatic void model_tick(input outs_t e);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (mem_rvalid && m_phase != 2) m_err = 1'b1;
      if (ir && !e.igt) m_starve = (m_starve + 1 > int'(LIMIT)) ? int'(LIMIT) : m_starve + 1;
      else m_starve = 0;
      if (m_phase == 0 && e.req) begin
        m_own_data = m_sel_data;
        m_phase = mem_gnt ? 2 : 1;
      end else if (m_phase == 1 && mem_gnt) begin
        m_phase = 2;
      end else if (m_phase == 2 && mem_rvalid) begin
        m_phase = 0;
      end
    end
  endfunction

  function automatic outs_t act_outs();
    return '{req: mreq, we: mwe, be: mbe, addr: maddr, wdata: mwdata, igt: igt, dgt: dgt,
             irv: irv, drv: drv, irdata: irdata, drdata: drdata, busy: busy, err: perr};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called settled mid-cycle: compare to model, clock, advance model, return just after edge
  task automatic step(input string name, output outs_t e);
    e = model_outs();
    chk(name, 160'(act_outs()), 160'(e));
    @(posedge clk);
    model_tick(e);
    #1;
  endtask

  task automatic idle_inputs();
    ir = 0; ia = 0; dr = 0; dwe = 0; dbe = 0; da = 0; dwd = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    model_reset();
    #1 rst_n = 1;
  endtask

  vec_t  vecs[7];
  outs_t e;
  int    first_i, second_i;

  initial begin
    vecs[0] = '{0, 32'h0,   0, 0, 4'h0, 32'h0,    32'h0,        0, 32'h0,
                0, 0, 4'h0, 32'h0,    32'h0,        0, 0};
    vecs[1] = '{1, 32'h100, 0, 0, 4'h0, 32'h0,    32'h0,        1, 32'h13,
                1, 0, 4'hF, 32'h100,  32'h0,        1, 0};
    vecs[2] = '{1, 32'h104, 0, 1, 4'h3, 32'h2000, 32'hBEEF,     0, 32'h0,
                1, 0, 4'hF, 32'h104,  32'h0,        0, 0};
    vecs[3] = '{0, 32'h0,   1, 1, 4'h3, 32'h2000, 32'hDEADBEEF, 1, 32'h55,
                1, 1, 4'h3, 32'h2000, 32'hDEADBEEF, 0, 1};
    vecs[4] = '{1, 32'h100, 1, 1, 4'hC, 32'h3000, 32'h12345678, 1, 32'h0,
                1, 1, 4'hC, 32'h3000, 32'h12345678, 0, 1};
    vecs[5] = '{0, 32'h0,   1, 0, 4'hF, 32'h44,   32'h0,        0, 32'hA5A5A5A5,
                1, 0, 4'hF, 32'h44,   32'h0,        0, 0};
    vecs[6] = '{0, 32'h999, 0, 1, 4'h7, 32'h88,   32'h77,       1, 32'h0,
                0, 0, 4'h0, 32'h0,    32'h0,        0, 0};

    do_reset();
    #2 chk("reset_outs", 160'(act_outs()), 160'h0);

    // IDLE combinational table; inputs withdrawn before each edge so state stays IDLE
    for (int i = 0; i < 7; i++) begin
      ir = vecs[i].ir; ia = vecs[i].ia; dr = vecs[i].dr; dwe = vecs[i].dwe;
      dbe = vecs[i].dbe; da = vecs[i].da; dwd = vecs[i].dwd;
      mem_gnt = vecs[i].gnt; mem_rdata = vecs[i].rdata;
      #2;
      chk($sformatf("vec%0d", i),
          160'({mreq, mwe, mbe, maddr, mwdata, igt, dgt, irdata, drdata, busy, irv, drv}),
          160'({vecs[i].e_req, vecs[i].e_we, vecs[i].e_be, vecs[i].e_addr, vecs[i].e_wd,
                vecs[i].e_igt, vecs[i].e_dgt, vecs[i].rdata, vecs[i].rdata, 3'b000}));
      idle_inputs();
      @(posedge clk);
      #1;
    end

    // Single fetch
    ir = 1; ia = 32'h100; mem_gnt = 1;
    #2 chk("single_gnt", 160'({igt, dgt, mreq, busy}), 160'(4'b1010));
    step("single_c0", e);
    ir = 0; mem_rvalid = 1; mem_rdata = 32'h13;
    #2 chk("single_rsp", 160'({irv, drv, busy, mreq}), 160'(4'b1010));
    chk("single_rdata", 160'(irdata), 160'(32'h13));
    step("single_c1", e);
    mem_rvalid = 0;
    #2 chk("single_done", 160'({busy, perr}), 160'(2'b00));
    step("single_c2", e);

    // Contention: data store first, fetch on next IDLE
    ir = 1; ia = 32'h100; dr = 1; dwe = 1; dbe = 4'h3; da = 32'h2000; dwd = 32'hDEADBEEF;
    #2 chk("cont_data", 160'({dgt, igt, mwe, mbe, maddr, mwdata}),
           160'({1'b1, 1'b0, 1'b1, 4'h3, 32'h2000, 32'hDEADBEEF}));
    step("cont_c0", e);
    dr = 0; dwe = 0; dbe = 0; da = 0; dwd = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE;
    #2 chk("cont_drsp", 160'({drv, irv, igt}), 160'(3'b100));
    step("cont_c1", e);
    mem_rvalid = 0;
    #2 chk("cont_instr", 160'({igt, dgt, mwe, mbe, maddr}), 160'({3'b100, 4'hF, 32'h100}));
    step("cont_c2", e);
    ir = 0; mem_rvalid = 1;
    #2 chk("cont_irsp", 160'({irv, drv}), 160'(2'b10));
    step("cont_c3", e);
    idle_inputs();

    // Grant stall with fetch owner locked while data arrives
    ir = 1; ia = 32'h300;
    #2 chk("stall_c0", 160'({igt, mreq}), 160'(2'b01));
    step("stall_m0", e);
    dr = 1; da = 32'h4000; dwe = 0; dbe = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #2 chk($sformatf("stall_hold%0d", k), 160'({dgt, igt, busy, maddr}), 160'({3'b001, 32'h300}));
      step("stall_m", e);
    end
    mem_gnt = 1;
    #2 chk("stall_gnt", 160'({igt, dgt, maddr}), 160'({2'b10, 32'h300}));
    step("stall_m4", e);
    ir = 0; mem_rvalid = 1;
    #2 chk("stall_rsp", 160'({irv, dgt}), 160'(2'b10));
    step("stall_m5", e);
    mem_rvalid = 0;
    #2 chk("stall_data", 160'({dgt, maddr}), 160'({1'b1, 32'h4000}));
    step("stall_m6", e);
    dr = 0; mem_rvalid = 1;
    #2 step("stall_m7", e);
    idle_inputs();

    // Starvation: both ports always requesting, memory always ready
    do_reset();
    first_i = -1; second_i = -1;
    for (int c = 0; c < 16; c++) begin
      ir = 1; ia = 32'h500; dr = 1; dwe = 1; dbe = 4'hF; da = 32'h600; dwd = 32'h1;
      mem_gnt = 1; mem_rvalid = (m_phase == 2);
      #2;
      if (igt === 1'b1 && first_i < 0) first_i = c;
      else if (igt === 1'b1 && second_i < 0) second_i = c;
      step("starve", e);
    end
    chk("starve_first", 160'(first_i), 160'(4));
    chk("starve_second", 160'(second_i), 160'(10));
    idle_inputs();
    mem_rvalid = (m_phase == 2);
    #2 step("starve_drain", e);
    mem_rvalid = 0;

    // Spurious response in IDLE
    do_reset();
    mem_rvalid = 1;
    #2 chk("spur_same", 160'({irv, drv, perr}), 160'(3'b000));
    step("spur_c0", e);
    mem_rvalid = 0;
    for (int k = 0; k < 3; k++) begin
      #2 chk($sformatf("spur_sticky%0d", k), 160'(perr), 160'(1));
      step("spur_m", e);
    end
    rst_n = 0;
    #2 step("spur_rst", e);
    rst_n = 1;
    #2 chk("spur_cleared", 160'(perr), 160'(0));
    step("spur_m2", e);

    // Reset while awaiting a response, then a stale response
    ir = 1; ia = 32'h700; mem_gnt = 1;
    #2 step("rst_c0", e);
    ir = 0; mem_gnt = 0; rst_n = 0;
    #2 chk("rst_in_resp", 160'(busy), 160'(1));
    step("rst_c1", e);
    rst_n = 1;
    #2 chk("rst_outs", 160'(act_outs()), 160'h0);
    step("rst_c2", e);
    mem_rvalid = 1; mem_rdata = 32'h77;
    #2 chk("stale_rv", 160'({irv, drv}), 160'(2'b00));
    step("rst_c3", e);
    mem_rvalid = 0;
    #2 chk("stale_err", 160'(perr), 160'(1));
    step("rst_c4", e);

    // Randomized traffic; requesters hold until granted
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (!ir && $urandom_range(0, 2) == 0) begin
        ir = 1; ia = $urandom;
      end
      if (!dr && $urandom_range(0, 2) == 0) begin
        dr = 1; dwe = 1'($urandom); dbe = 4'($urandom); da = $urandom; dwd = $urandom;
      end
      mem_gnt    = ($urandom_range(0, 3) != 0);
      mem_rvalid = (m_phase == 2) && ($urandom_range(0, 1) == 1);
      mem_rdata  = $urandom;
      #2 step("rand", e);
      if (e.igt) ir = 0;
      if (e.dgt) dr = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
